serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- Uses a single full-subtractor cell plus a borrow flip-flop.
- Start/busy/done handshake; the inverse-operation companion to the adder blocks in the arithmetic library.
- Trades latency (WIDTH+1 cycles) for area; intended for slow control-path arithmetic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal: 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block can accept.
- a  input  WIDTH  minuend; sampled on the accepted start cycle only.
- b  input  WIDTH  subtrahend; sampled on the accepted start cycle only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result registers update.
- diff  output  WIDTH  registered result, a - b mod 2^WIDTH.
- borrow  output  1  unsigned borrow out (1 when a < b unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: all registers are cleared on a rising clk edge with rst=1, and rst has priority over everything.
  - State is IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0; counter and internal borrow are 0.
  - Asserting rst mid-operation aborts it: no done pulse, outputs cleared.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: start=1 latches a into shift reg A and b into shift reg B, clears the borrow FF and counter, and moves to SHIFT. busy rises on the next cycle.
  - SHIFT: busy=1. Each cycle the cell computes d = A[0]^B[0]^bff and bnext = (~A[0]&B[0]) | (~(A[0]^B[0])&bff).
    - d shifts into the MSB of work reg R, and A and B shift right.
    - bff <= bnext and cnt++.
    - When cnt reaches WIDTH-1 (last bit), go to DONE.
  - DONE: lasts one cycle; busy=0, done=1.
    - diff <= R and borrow <= bff (final borrow).
    - ovf <= (a_msb != b_msb) && (R[WIDTH-1] != a_msb), using the latched operand MSBs.
    - Next state is IDLE, or SHIFT directly if start=1 in this cycle (back-to-back accept, same latch action as IDLE).
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH. Result outputs change exactly at that edge.
- start while in SHIFT is ignored, with no queuing. start while rst=1 is ignored.
- diff, borrow and ovf hold their last values until the next done. They do not change during SHIFT.
- a and b may change freely after the accept cycle without affecting the result.
- Width rules: the internal borrow is 1 bit; no operand sign-extension; the result is modulo 2^WIDTH.

Decomposition:
- Shared arithmetic package:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Default WIDTH constant.
- Sub-module full_subtractor (a, b, bin -> d, bout), purely combinational, instantiated once. It is the mirror of the existing full_adder cell and is unit-tested exhaustively on its own.

Test Plan:
- full_subtractor: all 8 (a,b,bin) combos -> d = a^b^bin, and bout per truth table (e.g. 0,1,0 -> d=1, bout=1; 1,1,1 -> d=1, bout=1).
- WIDTH=8, a=0x05, b=0x03, start pulse -> done exactly 9 cycles after accept edge, diff=0x02, borrow=0, ovf=0. busy is high for 8 cycles.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
- a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1. During SHIFT, change a/b and pulse start -> result unaffected, no extra done.
- Back-to-back: start held in the DONE cycle with a=0x10, b=0x10 -> second done 9 cycles later with diff=0x00, borrow=0. No IDLE cycle between the operations.
- rst asserted for one cycle at bit 4 of an operation -> next edge has busy=0, done=0, diff=0, borrow=0, ovf=0. No done follows, and a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM encoding and default width for the serial subtractor
package serial_subtractor_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit subtract cell, mirror of the full_adder cell
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);
    state_t             state;
    logic [WIDTH-1:0]   ra, rb, rr;
    logic [CNT_W-1:0]   cnt;
    logic               bff, a_msb, b_msb, d, bout;
    logic [WIDTH-1:0]   rr_next;
    logic               last, accept;

    full_subtractor u_fs (.a(ra[0]), .b(rb[0]), .bin(bff), .d(d), .bout(bout));

    assign rr_next = {d, rr[WIDTH-1:1]};
    assign last    = cnt == CNT_W'(WIDTH - 1);
    assign accept  = start && (state == IDLE || state == DONE);

    // results are registered on the last shift edge so done and diff rise together
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            rr     <= '0;
            cnt    <= '0;
            bff    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ra    <= a;
                rb    <= b;
                rr    <= '0;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                bff   <= 1'b0;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= SHIFT;
            end else if (state == SHIFT) begin
                ra  <= ra >> 1;
                rb  <= rb >> 1;
                rr  <= rr_next;
                bff <= bout;
                cnt <= cnt + 1'b1;
                if (last) begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    diff   <= rr_next;
                    borrow <= bout;
                    ovf    <= (a_msb != b_msb) && (d != a_msb);
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors checked against an arithmetic model every cycle
module tb_serial_subtractor;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0] a = '0, b = '0, diff;
    logic       busy, done, borrow, ovf;
    int         vectors = 0, miscompares = 0;
    logic       checking = 1'b0;

    logic       m_busy = 0, m_done = 0, m_borrow = 0, m_ovf = 0;
    logic       p_borrow = 0, p_ovf = 0;
    logic [7:0] m_diff = 0, p_diff = 0;
    int         m_left = 0;

    logic fa, fb, fbin, fd, fbo;
    logic [7:0] d_tab = 8'b1001_0110, bo_tab = 8'b1000_1110;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
    );
    full_subtractor u_fs (.a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbo));

    always #5 clk = ~clk;

    function automatic logic sovf(input logic [7:0] x, input logic [7:0] y);
        int s;
        s = int'($signed(x)) - int'($signed(y));
        return s > 127 || s < -128;
    endfunction

    // model: an accepted operation finishes 8 edges later; accepts only when idle or finishing
    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0; m_busy <= 0; m_done <= 0;
            m_diff <= 0; m_borrow <= 0; m_ovf <= 0;
        end else begin
            m_done <= 0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 0; m_done <= 1;
                    m_diff <= p_diff; m_borrow <= p_borrow; m_ovf <= p_ovf;
                end
            end else if (start) begin
                m_left <= 8; m_busy <= 1;
                p_diff <= a - b; p_borrow <= a < b; p_ovf <= sovf(a, b);
            end
        end
    end

    always @(negedge clk) if (checking) begin
        vectors++;
        if ({busy, done, diff, borrow, ovf} !== {m_busy, m_done, m_diff, m_borrow, m_ovf}) begin
            miscompares++;
            $display("FAIL model t=%0t got busy=%b done=%b diff=%h borrow=%b ovf=%b expected busy=%b done=%b diff=%h borrow=%b ovf=%b",
                     $time, busy, done, diff, borrow, ovf, m_busy, m_done, m_diff, m_borrow, m_ovf);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm, input logic [7:0] ed, input logic eb, input logic eo,
                             input bit disturb);
        int n = 0, nb = 0;
        bit seen = 0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (disturb && n == 3) begin a = 8'h11; b = 8'h22; start = 1; end
            if (disturb && n == 4) start = 0;
            seen = done;
        end
        chk({nm, "_latency"}, n, 9);
        chk({nm, "_busy_cycles"}, nb, 8);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_borrow"}, borrow, eb);
        chk({nm, "_ovf"}, ovf, eo);
    endtask

    task automatic op(input string nm, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] ed, input logic eb, input logic eo, input bit disturb);
        @(negedge clk);
        a = x; b = y; start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_done(nm, ed, eb, eo, disturb);
    endtask

    task automatic quiet(input string nm, input int cycles);
        int dn = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk({nm, "_no_done"}, dn, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            {fa, fb, fbin} = 3'(i);
            #1;
            chk($sformatf("fs_d_%0d", i), fd, d_tab[i]);
            chk($sformatf("fs_bout_%0d", i), fbo, bo_tab[i]);
        end
        repeat (2) @(posedge clk);
        checking = 1;
        @(negedge clk);
        chk("reset_outputs", {busy, done, diff, borrow, ovf}, 0);
        rst = 0;
        op("t05_03", 8'h05, 8'h03, 8'h02, 0, 0, 0);
        op("t03_05", 8'h03, 8'h05, 8'hFE, 1, 0, 0);
        op("t80_01", 8'h80, 8'h01, 8'h7F, 0, 1, 0);
        op("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1, 1, 1);
        quiet("after_disturb", 12);
        chk("hold_diff", diff, 8'h80);
        op("t20_01", 8'h20, 8'h01, 8'h1F, 0, 0, 0);
        a = 8'h10; b = 8'h10; start = 1;
        @(posedge clk);
        #1 start = 0;
        chk("b2b_busy_immediate", busy, 1);
        wait_done("b2b", 8'h00, 0, 0, 0);
        op("pre", 8'hFF, 8'h01, 8'hFE, 0, 0, 0);
        @(negedge clk);
        a = 8'h55; b = 8'h22; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1 chk("mid_reset", {busy, done, diff, borrow, ovf}, 0);
        @(negedge clk);
        rst = 0;
        quiet("after_reset", 12);
        op("t33_11", 8'h33, 8'h11, 8'h22, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
